uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_ctrl_if.sv | 15 +
 rtl/uart_sync2.sv | 27 ++
 rtl/uart_rx_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, frame defaults
// and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  localparam int   DEF_DATA_BITS = 8;
  localparam int   MIN_DIV       = 4;
  localparam logic LINE_IDLE     = 1'b1;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Received-byte handshake between the UART receiver (master) and its consumer.
interface uart_rx_ctrl_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input  rx_ready);
  modport slave  (input  rx_data, input  rx_valid, output rx_ready);

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability filter chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 8N1-style framing sampled mid-bit with a programmable divider,
// single-entry output buffer with valid/ready handshake.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int DIV_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_rx,
  input  logic [DIV_W-1:0] clk_div,
  uart_rx_ctrl_if.master   rx_bus,
  output logic             frame_err,
  output logic             overrun,
  output logic             rx_busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);

  logic                 rx_s;
  rx_state_e            state_r, state_n;
  logic [DIV_W-1:0]     div_r, div_n, cnt_r, cnt_n, div_in_s;
  logic [IDX_W-1:0]     idx_r, idx_n;
  logic [DATA_BITS-1:0] shift_r, shift_n, rx_data_r;
  logic                 rx_valid_r, frame_err_r, overrun_r, rx_busy_r;
  logic                 tick_s, good_s, ferr_s;

  uart_sync2 #(.RST_VAL(LINE_IDLE)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ser_rx),
    .q     (rx_s)
  );

  // Undefined divisors are clamped so the half-period load cannot underflow.
  assign div_in_s = (clk_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clk_div;
  assign tick_s   = (cnt_r == {DIV_W{1'b0}});

  // FSM and datapath state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      div_r   <= {DIV_W{1'b0}};
      cnt_r   <= {DIV_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      shift_r <= {DATA_BITS{1'b0}};
    end else begin
      state_r <= state_n;
      div_r   <= div_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      shift_r <= shift_n;
    end
  end

  // Next-state, bit timing and sampling decisions
  always_comb begin
    state_n = state_r;
    div_n   = div_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    shift_n = shift_r;
    good_s  = 1'b0;
    ferr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_s == 1'b0) begin
          div_n   = div_in_s;
          cnt_n   = (div_in_s >> 1) - DIV_W'(1);
          state_n = ST_START;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          cnt_n   = div_r - DIV_W'(1);
          idx_n   = {IDX_W{1'b0}};
          state_n = (rx_s == 1'b0) ? ST_DATA : ST_IDLE;
        end else begin
          cnt_n = cnt_r - DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          cnt_n   = div_r - DIV_W'(1);
          shift_n = DATA_BITS'({rx_s, shift_r} >> 1);
          if (idx_r == IDX_W'(DATA_BITS - 1)) begin
            idx_n   = {IDX_W{1'b0}};
            state_n = ST_STOP;
          end else begin
            idx_n = idx_r + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt_r - DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          cnt_n = {DIV_W{1'b0}};
          if (rx_s == 1'b1) begin
            good_s  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_n = ST_WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt_r - DIV_W'(1);
        end
      end
      ST_WAIT_HIGH: begin
        // A held-low (break) line must rise before a new start is accepted.
        if (rx_s == 1'b1) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Output buffer, handshake and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r   <= {DATA_BITS{1'b0}};
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      rx_busy_r   <= 1'b0;
    end else begin
      frame_err_r <= ferr_s;
      rx_busy_r   <= (state_n != ST_IDLE);
      if (good_s && rx_valid_r && !rx_bus.rx_ready) begin
        overrun_r <= 1'b1;
      end else if (good_s) begin
        overrun_r  <= 1'b0;
        rx_data_r  <= shift_r;
        rx_valid_r <= 1'b1;
      end else if (rx_valid_r && rx_bus.rx_ready) begin
        overrun_r  <= 1'b0;
        rx_valid_r <= 1'b0;
      end else begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign rx_bus.rx_data  = rx_data_r;
  assign rx_bus.rx_valid = rx_valid_r;
  assign frame_err       = frame_err_r;
  assign overrun         = overrun_r;
  assign rx_busy         = rx_busy_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frame scenarios plus random
// frames scored against a frame-level reference (queue of expected bytes).
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ser_rx;
  logic [15:0] clk_div;
  logic        frame_err;
  logic        overrun;
  logic        rx_busy;

  uart_rx_ctrl_if #(.DATA_BITS(8)) bus ();

  uart_rx_ctrl #(.DATA_BITS(8), .DIV_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_rx    (ser_rx),
    .clk_div   (clk_div),
    .rx_bus    (bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  int         n_checks;
  int         n_errs;
  int         ferr_cnt;
  int         ovr_cnt;
  int         exp_ferr;
  int         exp_ovr;
  int         lat;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer-side monitor: record accepted bytes and status pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame, LSB first, each bit held for div clocks.
  task automatic send_frame(input logic [7:0] b, input int div, input logic stop_lvl);
    ser_rx = 1'b0;
    wait_cyc(div);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      wait_cyc(div);
    end
    ser_rx = stop_lvl;
    wait_cyc(div);
  endtask

  task automatic score(input string tag);
    chk_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk_eq({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
    chk_eq({tag, "_ferr"}, ferr_cnt, exp_ferr);
    chk_eq({tag, "_ovr"}, ovr_cnt, exp_ovr);
  endtask

  initial begin
    logic [7:0] b;
    int         d;
    logic       ok;
    n_checks = 0; n_errs = 0; ferr_cnt = 0; ovr_cnt = 0; exp_ferr = 0; exp_ovr = 0;
    rst_n = 1'b0; ser_rx = 1'b1; clk_div = 16'd16; bus.rx_ready = 1'b1;
    wait_cyc(3);
    chk_eq("rst_data", {24'd0, bus.rx_data}, 32'd0);
    chk_eq("rst_valid", bus.rx_valid, 32'd0);
    chk_eq("rst_ferr", frame_err, 32'd0);
    chk_eq("rst_ovr", overrun, 32'd0);
    chk_eq("rst_busy", rx_busy, 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Good frame: 2 sync + 1 detect + div/2 + 9*div clocks to rx_valid.
    fork
      send_frame(8'hA5, 16, 1'b1);
      begin
        lat = 0;
        while (lat < 300 && !bus.rx_valid) begin
          @(posedge clk);
          #1;
          lat++;
        end
        chk_eq("a5_latency", (lat >= 154 && lat <= 156) ? 32'd155 : lat, 32'd155);
        chk_eq("a5_data", {24'd0, bus.rx_data}, 32'hA5);
        wait_cyc(1);
        chk_eq("a5_valid_1cyc", bus.rx_valid, 32'd0);
      end
    join
    exp_q.push_back(8'hA5);
    wait_cyc(4);
    score("a5");

    // Glitch shorter than half a bit is rejected.
    ser_rx = 1'b0;
    wait_cyc(5);
    ser_rx = 1'b1;
    wait_cyc(20);
    chk_eq("glitch_busy", rx_busy, 32'd0);
    score("glitch");
    send_frame(8'h3C, 16, 1'b1);
    exp_q.push_back(8'h3C);
    wait_cyc(5);
    score("3c");

    // Framing error followed by a break.
    clk_div = 16'd10;
    send_frame(8'h55, 10, 1'b0);
    wait_cyc(40);
    chk_eq("break_busy", rx_busy, 32'd1);
    ser_rx = 1'b1;
    exp_ferr++;
    wait_cyc(6);
    score("ferr");
    send_frame(8'h81, 10, 1'b1);
    exp_q.push_back(8'h81);
    wait_cyc(5);
    score("81");

    // Overrun, then a new frame landing in the same cycle as a consume.
    clk_div = 16'd16;
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 16, 1'b1);
    wait_cyc(6);
    chk_eq("ovr_valid", bus.rx_valid, 32'd1);
    send_frame(8'h22, 16, 1'b1);
    wait_cyc(6);
    exp_ovr++;
    chk_eq("ovr_pulse", ovr_cnt, exp_ovr);
    chk_eq("ovr_hold", {24'd0, bus.rx_data}, 32'h11);
    fork
      send_frame(8'h33, 16, 1'b1);
      begin
        wait_cyc(154);
        bus.rx_ready = 1'b1;
        wait_cyc(1);
        bus.rx_ready = 1'b0;
      end
    join
    chk_eq("same_cyc_data", {24'd0, bus.rx_data}, 32'h33);
    chk_eq("same_cyc_valid", bus.rx_valid, 32'd1);
    bus.rx_ready = 1'b1;
    wait_cyc(3);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h33);
    score("ovr");

    // Reset in the middle of the data bits of 0xF0.
    b = 8'hF0;
    ser_rx = 1'b0;
    wait_cyc(16);
    for (int i = 0; i < 4; i++) begin
      ser_rx = b[i];
      wait_cyc(16);
    end
    chk_eq("mid_busy", rx_busy, 32'd1);
    rst_n = 1'b0;
    ser_rx = 1'b1;
    wait_cyc(2);
    chk_eq("mrst_data", {24'd0, bus.rx_data}, 32'd0);
    chk_eq("mrst_valid", bus.rx_valid, 32'd0);
    chk_eq("mrst_busy", rx_busy, 32'd0);
    chk_eq("mrst_ferr", frame_err, 32'd0);
    chk_eq("mrst_ovr", overrun, 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);
    send_frame(8'h0F, 16, 1'b1);
    exp_q.push_back(8'h0F);
    wait_cyc(5);
    score("0f");

    // Divider change mid-frame applies only to the next frame.
    fork
      send_frame(8'h96, 16, 1'b1);
      begin
        wait_cyc(40);
        clk_div = 16'd8;
      end
    join
    exp_q.push_back(8'h96);
    wait_cyc(4);
    send_frame(8'h69, 8, 1'b1);
    exp_q.push_back(8'h69);
    wait_cyc(5);
    score("div");

    // Random frames, divisors, stop levels and gaps.
    for (int n = 0; n < 24; n++) begin
      b  = 8'($urandom);
      d  = int'($urandom_range(4, 24));
      ok = ($urandom_range(0, 3) != 0);
      clk_div = 16'(d);
      send_frame(b, d, ok);
      if (ok) begin
        exp_q.push_back(b);
      end else begin
        exp_ferr++;
        wait_cyc(int'($urandom_range(0, 30)));
        ser_rx = 1'b1;
      end
      wait_cyc(int'($urandom_range(4, 8)));
    end
    score("rand");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
